// File: rtl/mul_pkg.sv
// Shared width constants, operand/product types and a reference multiply for the multiplier block.
// The reference uses repeated addition so it stays independent of the shift-and-add array.
package mul_pkg;

   localparam int MUL_N = 4;

   typedef logic [MUL_N-1:0]   operand_t;
   typedef logic [2*MUL_N-1:0] product_t;

   function automatic product_t ref_mul(input operand_t a, input operand_t b);
      product_t r;
      r = '0;
      for (int i = 0; i < (1 << MUL_N); i++) begin
         if (i < int'(b)) r = r + product_t'(a);
      end
      return r;
   endfunction

endpackage

// File: rtl/mul_add_row.sv
// One multiplier array row: sum = acc + ((b_bit ? a : 0) << SHIFT), combinational ripple carry.
// Latency 0; no flow control. The final carry-out is never needed because the product cannot overflow 2N bits.
module mul_add_row
   import mul_pkg::*;
#(
   parameter int N     = MUL_N,
   parameter int SHIFT = 1
) (
   input  logic [2*N-1:0] acc,
   input  logic [N-1:0]   a,
   input  logic           b_bit,
   output logic [2*N-1:0] sum
);

   localparam int W = 2 * N;

   logic [W-1:0] pp;
   logic [W-1:0] carry;

   assign pp       = {{N{1'b0}}, a & {N{b_bit}}} << SHIFT;
   assign carry[0] = 1'b0;

   for (genvar i = 0; i < W; i++) begin : g_bit
      assign sum[i] = acc[i] ^ pp[i] ^ carry[i];
      if (i < W - 1) begin : g_carry
         assign carry[i+1] = (acc[i] & pp[i]) | (carry[i] & (acc[i] ^ pp[i]));
      end
   end

endmodule

// File: rtl/mul_unit.sv
// Unsigned N x N multiplier: combinational 2N-bit product Y plus a 1-cycle registered copy Y_q/out_valid.
// No backpressure: a product is captured on every edge where in_valid is high; Y_q holds otherwise.
module mul_unit
   import mul_pkg::*;
#(
   parameter int N = MUL_N
) (
   output logic [2*N-1:0] Y,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   input  logic           CLK,
   input  logic           n_Reset,
   input  logic           in_valid,
   output logic [2*N-1:0] Y_q,
   output logic           out_valid
);

   // row_sum[i] is the running sum of partial products 0..i
   logic [2*N-1:0] row_sum [N];

   assign row_sum[0] = {{N{1'b0}}, A & {N{B[0]}}};

   for (genvar i = 1; i < N; i++) begin : g_row
      mul_add_row #(
         .N     (N),
         .SHIFT (i)
      ) u_row (
         .acc   (row_sum[i-1]),
         .a     (A),
         .b_bit (B[i]),
         .sum   (row_sum[i])
      );
   end

   assign Y = row_sum[N-1];

   always_ff @(posedge CLK or negedge n_Reset) begin
      if (!n_Reset) begin
         Y_q       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) Y_q <= Y;
      end
   end

endmodule

// File: tb/tb_mul_unit.sv
// Directed and exhaustive checks of mul_unit (N=4): combinational product, registered path, hold and async reset.
`timescale 1ns/1ps
module tb_mul_unit;
   import mul_pkg::*;

   logic [7:0] Y, Y_q;
   logic [3:0] A, B;
   logic       CLK, n_Reset, in_valid, out_valid;

   int n_checks = 0;
   int n_fail   = 0;

   mul_unit #(.N(4)) dut (
      .Y         (Y),
      .A         (A),
      .B         (B),
      .CLK       (CLK),
      .n_Reset   (n_Reset),
      .in_valid  (in_valid),
      .Y_q       (Y_q),
      .out_valid (out_valid)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] y;
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{a: 4'd0,  b: 4'd0,  y: 8'd0};
      vecs[1] = '{a: 4'd15, b: 4'd15, y: 8'd225};
      vecs[2] = '{a: 4'd3,  b: 4'd5,  y: 8'd15};
      vecs[3] = '{a: 4'd1,  b: 4'd15, y: 8'd15};
      vecs[4] = '{a: 4'd8,  b: 4'd2,  y: 8'd16};
      vecs[5] = '{a: 4'd15, b: 4'd1,  y: 8'd15};
      vecs[6] = '{a: 4'd0,  b: 4'd9,  y: 8'd0};
      vecs[7] = '{a: 4'd6,  b: 4'd7,  y: 8'd42};

      // reset state
      A = 4'd0; B = 4'd0; in_valid = 1'b0; n_Reset = 1'b0;
      #12;
      check("reset_y_q", 32'(Y_q), 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      @(negedge CLK);
      n_Reset = 1'b1;

      // directed vectors
      foreach (vecs[k]) begin
         @(negedge CLK);
         A = vecs[k].a; B = vecs[k].b; in_valid = 1'b1;
         #0.01;
         check($sformatf("vec%0d_y", k), 32'(Y), 32'(vecs[k].y));
         @(posedge CLK); #1;
         check($sformatf("vec%0d_y_q", k), 32'(Y_q), 32'(vecs[k].y));
         check($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'd1);
      end

      // exhaustive stream, in_valid high every cycle
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            @(negedge CLK);
            A = 4'(a); B = 4'(b); in_valid = 1'b1;
            #0.01;
            check($sformatf("exh_y_%0dx%0d", a, b), 32'(Y), 32'(a * b));
            @(posedge CLK); #1;
            check($sformatf("exh_y_q_%0dx%0d", a, b), 32'(Y_q), 32'(a * b));
         end
      end

      // in_valid 1,0,1: hold through idle cycle
      @(negedge CLK);
      A = 4'd7; B = 4'd9; in_valid = 1'b1;
      @(posedge CLK); #1;
      check("tog_y_q_63", 32'(Y_q), 32'd63);
      check("tog_ov_1", 32'(out_valid), 32'd1);
      @(negedge CLK);
      A = 4'd2; B = 4'd3; in_valid = 1'b0;
      #0.01;
      check("tog_idle_y", 32'(Y), 32'd6);
      @(posedge CLK); #1;
      check("tog_hold_y_q", 32'(Y_q), 32'd63);
      check("tog_idle_ov", 32'(out_valid), 32'd0);
      @(negedge CLK);
      in_valid = 1'b1;
      @(posedge CLK); #1;
      check("tog_y_q_6", 32'(Y_q), 32'd6);
      check("tog_ov_again", 32'(out_valid), 32'd1);

      // async reset mid-stream
      @(negedge CLK);
      A = 4'd15; B = 4'd15; in_valid = 1'b1;
      @(posedge CLK); #1;
      check("rst_pre_y_q", 32'(Y_q), 32'd225);
      #1;
      n_Reset = 1'b0;
      #0.01;
      check("rst_async_y_q", 32'(Y_q), 32'd0);
      check("rst_async_ov", 32'(out_valid), 32'd0);
      check("rst_y_live", 32'(Y), 32'd225);
      @(posedge CLK); #1;
      check("rst_held_y_q", 32'(Y_q), 32'd0);
      check("rst_held_ov", 32'(out_valid), 32'd0);
      @(negedge CLK);
      n_Reset = 1'b1;
      A = 4'd3; B = 4'd5; in_valid = 1'b1;
      @(posedge CLK); #1;
      check("rst_release_y_q", 32'(Y_q), 32'd15);
      check("rst_release_ov", 32'(out_valid), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
